attn_v_matmul: RTL and testbench
================================

# attn_v_matmul

Downstream neighbour of `softmax` in the MHA datapath. Consumes one row of attention probabilities (`DIM` lanes, signed Q2.13) and a `DIM`×`DIM` value matrix V, and produces one output row O[j] = Σk P[k]·V[k][j] in the same fixed-point format. It uses a multi-cycle MAC loop over k with `DIM` parallel lanes. Its start/valid handshake matches `softmax`, so `softmax.O_VLD`/`O_DATA` can drive `I_START`/`I_DATA` directly.

## Interface
- `D_W`, 16: element width, signed two's complement.
- `DIM`, 4: row length and V dimension; ≥2, power of two.
- `FRAC`, 13: fractional bits; 1.0 = 2^FRAC = 8192.
- `I_CLK`  in  1  clock, rising edge.
- `I_RST_N`  in  1  reset, asynchronous, active-low.
- `I_START`  in  1  request; held high for the whole computation and until result consumed.
- `I_DATA`  in  D_W*DIM  probabilities; P[k] = `I_DATA[k*D_W +: D_W]`.
- `I_V`  in  D_W*DIM*DIM  value matrix; V[k][j] = `I_V[(k*DIM+j)*D_W +: D_W]`.
- `O_VLD`  out  1  result valid (level).
- `O_DATA`  out  D_W*DIM  result; O[j] = `O_DATA[j*D_W +: D_W]`.

## Operation
- States: IDLE, MAC, OUT, DONE.
- IDLE: on `I_START`=1, latch `I_DATA` and `I_V` into internal registers, clear all accumulators, set k=0, go to MAC. Inputs are don't-care after the latch edge.
- MAC: every lane j does acc[j] += P[k]·V[k][j] in signed, full precision. k increments. When k=DIM-1 is processed, go to OUT.
- OUT: per lane, r = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round half up). Saturate r to [-2^(D_W-1), 2^(D_W-1)-1]. Register the results into `O_DATA`, set `O_VLD`=1, go to DONE.
- DONE: hold `O_VLD`=1 and `O_DATA` stable while `I_START`=1. When `I_START`=0, clear `O_VLD` and go to IDLE.
- Widths:
  - Product is 2*D_W bits (Q4.26).
  - Accumulator is 2*D_W+$clog2(DIM) bits, so it never overflows.
  - Saturation is applied only at OUT.
- Abort: `I_START`=0 in MAC or OUT returns to IDLE on the next edge. `O_VLD` stays 0, accumulators are cleared, and `O_DATA` keeps its previous value.
- Restart needs `I_START` low for at least one cycle (through IDLE). A held-high `I_START` never retriggers.
- Input legality: P does not need to sum to 1, and any signed values are legal.

## Timing
- Reset: state=IDLE, `O_VLD`=0, `O_DATA`=0, accumulators=0, k=0.
- Latency: if `I_START` is first sampled high at edge t, `O_VLD` rises after edge t+DIM+1 (5 cycles for DIM=4).
- `O_VLD` falls on the first edge where `I_START`=0 is sampled in DONE.
- The earliest next start sample is one cycle after that.
- Reset asserted mid-operation clears everything immediately, with no output glitch beyond the reset values.
- All outputs are registered, with no combinational input-to-output path.

## Structure
- Shared package `mha_pkg` holds:
  - FRAC default.
  - State enum {IDLE, MAC, OUT, DONE}.
  - Accumulator-width localparam formula.
  - Shared with `softmax` and upstream score stage.
- One sub-module `fxp_round_sat` (params IN_W, OUT_W, FRAC): combinational round-half-up plus saturate. It is instantiated DIM times and can be reused by other MHA stages.
- MAC lanes are a generate loop in the top module. k is a $clog2(DIM)-bit counter.

## Test plan
- One-hot: P = {0,0,8192,0}, V row 2 = {4096,-8192,12288,-16384}, other rows random -> O_DATA = {4096,-8192,12288,-16384}. `O_VLD` is seen 5 cycles after start.
- Uniform: P[k] = 2048 for all k, V[k][j] = (k+1)·4096 -> every O[j] = 10240 (1.25).
- Saturation: all P = 8192, all V = 24576 -> O[j] = 32767. All V = -32768 -> O[j] = -32768.
- Rounding: P = {1,0,0,0}, V[0] = {4096,4095,-4096,-4097} -> O = {1,0,0,-1}.
- Abort/restart: drop `I_START` 2 cycles after start -> `O_VLD` never asserts and `O_DATA` is unchanged. Then low 1 cycle and restart with the one-hot vector -> correct result after DIM+1 cycles.
- Hold/capture: change `I_DATA`/`I_V` during MAC and DONE -> `O_DATA` is unaffected, and `O_VLD` stays high until `I_START` drops, clearing on the next edge. Asserting `I_RST_N`=0 mid-MAC -> all outputs are 0 immediately.

Source files
------------

// File: rtl/mha_pkg.sv
// Shared definitions for the multi-head-attention datapath stages
// (score, softmax, attention-times-V).
package mha_pkg;

  localparam int unsigned FRAC_DEFAULT = 13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT,
    S_DONE
  } state_e;

  // Full-precision accumulator: 2*D_W product bits plus growth for DIM terms.
  function automatic int unsigned acc_width(input int unsigned d_w, input int unsigned dim);
    return 2 * d_w + $clog2(dim);
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Fixed-point narrowing: drop FRAC fractional bits with round-half-up,
// then saturate to a signed OUT_W-bit result.
module fxp_round_sat #(
  parameter int unsigned IN_W  = 34,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned FRAC  = 13
) (
  input  logic [IN_W-1:0]  data_i,
  output logic [OUT_W-1:0] data_o
);

  // One extra bit of headroom so adding the rounding constant cannot wrap.
  localparam logic signed [IN_W:0] RND  = {{(IN_W + 1 - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
  localparam logic signed [IN_W:0] MAXV = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] shifted;

  always_comb begin
    sum     = $signed({data_i[IN_W-1], data_i}) + RND;
    shifted = sum >>> FRAC;
    if (shifted > MAXV) begin
      data_o = MAXV[OUT_W-1:0];
    end else if (shifted < MINV) begin
      data_o = MINV[OUT_W-1:0];
    end else begin
      data_o = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/attn_v_matmul.sv
// One output row O[j] = sum_k P[k]*V[k][j] in Q2.13, computed over DIM cycles
// with DIM parallel MAC lanes; start/valid handshake matches softmax.
module attn_v_matmul
  import mha_pkg::*;
#(
  parameter int unsigned D_W  = 16,
  parameter int unsigned DIM  = 4,
  parameter int unsigned FRAC = FRAC_DEFAULT
) (
  input  logic                     I_CLK,
  input  logic                     I_RST_N,
  input  logic                     I_START,
  input  logic [D_W*DIM-1:0]       I_DATA,
  input  logic [D_W*DIM*DIM-1:0]   I_V,
  output logic                     O_VLD,
  output logic [D_W*DIM-1:0]       O_DATA
);

  localparam int unsigned ACC_W = acc_width(D_W, DIM);
  localparam int unsigned K_W   = $clog2(DIM);
  localparam logic [K_W-1:0] K_LAST = K_W'(DIM - 1);

  state_e                 state_q;
  logic [K_W-1:0]         k_q;
  logic                   o_vld_q;
  logic [D_W*DIM-1:0]     o_data_q;
  logic signed [D_W-1:0]  p_q   [DIM];
  logic signed [D_W-1:0]  v_q   [DIM][DIM];
  logic signed [ACC_W-1:0] acc_q [DIM];

  logic signed [2*D_W-1:0] prod    [DIM];
  logic signed [ACC_W-1:0] acc_nxt [DIM];
  logic [D_W*DIM-1:0]      rs_flat;

  for (genvar j = 0; j < DIM; j++) begin : g_lane
    assign prod[j]    = p_q[k_q] * v_q[k_q][j];
    assign acc_nxt[j] = acc_q[j] + {{(ACC_W - 2*D_W){prod[j][2*D_W-1]}}, prod[j]};

    fxp_round_sat #(
      .IN_W  (ACC_W),
      .OUT_W (D_W),
      .FRAC  (FRAC)
    ) u_round_sat (
      .data_i (acc_q[j]),
      .data_o (rs_flat[j*D_W +: D_W])
    );
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      o_vld_q  <= 1'b0;
      o_data_q <= '0;
      for (int unsigned i = 0; i < DIM; i++) begin
        acc_q[i] <= '0;
        p_q[i]   <= '0;
        for (int unsigned j = 0; j < DIM; j++) v_q[i][j] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (I_START) begin
            for (int unsigned i = 0; i < DIM; i++) begin
              p_q[i]   <= I_DATA[i*D_W +: D_W];
              acc_q[i] <= '0;
              for (int unsigned j = 0; j < DIM; j++)
                v_q[i][j] <= I_V[(i*DIM + j)*D_W +: D_W];
            end
            k_q     <= '0;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          if (!I_START) begin
            for (int unsigned i = 0; i < DIM; i++) acc_q[i] <= '0;
            k_q     <= '0;
            state_q <= S_IDLE;
          end else begin
            for (int unsigned i = 0; i < DIM; i++) acc_q[i] <= acc_nxt[i];
            k_q <= k_q + 1'b1;
            if (k_q == K_LAST) state_q <= S_OUT;
          end
        end
        S_OUT: begin
          if (!I_START) begin
            for (int unsigned i = 0; i < DIM; i++) acc_q[i] <= '0;
            state_q <= S_IDLE;
          end else begin
            o_data_q <= rs_flat;
            o_vld_q  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          if (!I_START) begin
            o_vld_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign O_VLD  = o_vld_q;
  assign O_DATA = o_data_q;

endmodule

// File: tb/tb_attn_v_matmul.sv
// Directed bench for attn_v_matmul with hand-computed expected rows.
module tb_attn_v_matmul;

  localparam int unsigned D_W = 16;
  localparam int unsigned DIM = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   start;
  logic [D_W*DIM-1:0]     pdata;
  logic [D_W*DIM*DIM-1:0] vdata;
  logic                   vld;
  logic [D_W*DIM-1:0]     odata;

  int checks = 0;
  int errors = 0;
  int n;
  logic [D_W*DIM-1:0] saved;

  attn_v_matmul #(.D_W(D_W), .DIM(DIM), .FRAC(13)) dut (
    .I_CLK   (clk),
    .I_RST_N (rst_n),
    .I_START (start),
    .I_DATA  (pdata),
    .I_V     (vdata),
    .O_VLD   (vld),
    .O_DATA  (odata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    logic [15:0] ev;
    e = '{e0, e1, e2, e3};
    for (int j = 0; j < 4; j++) begin
      ev = e[j][15:0];
      checks++;
      assert (odata[j*16 +: 16] === ev) else begin
        errors++;
        $error("FAIL %s lane%0d observed=%0d expected=%0d", tag, j,
               $signed(odata[j*16 +: 16]), $signed(ev));
      end
    end
  endtask

  task automatic setp(input int a, input int b, input int c, input int d);
    pdata = {d[15:0], c[15:0], b[15:0], a[15:0]};
  endtask

  task automatic setv(input int k, input int a, input int b, input int c, input int d);
    vdata[(k*4+0)*16 +: 16] = a[15:0];
    vdata[(k*4+1)*16 +: 16] = b[15:0];
    vdata[(k*4+2)*16 +: 16] = c[15:0];
    vdata[(k*4+3)*16 +: 16] = d[15:0];
  endtask

  // Counts posedges from the start-sampling edge until O_VLD is seen (bounded).
  task automatic wait_vld(output int cnt);
    logic seen;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      seen = vld;
    end
  endtask

  task automatic drop_start(input string tag);
    start = 1'b0;
    @(negedge clk);
    chk(tag, {63'b0, vld}, 64'd0);
  endtask

  task automatic load_onehot();
    setp(0, 0, 8192, 0);
    setv(0, 1234, -777, 30000, -5);
    setv(1, -32768, 32767, 99, 4242);
    setv(2, 4096, -8192, 12288, -16384);
    setv(3, 555, -20000, 7, 31000);
  endtask

  task automatic load_uniform();
    setp(2048, 2048, 2048, 2048);
    for (int k = 0; k < 4; k++) setv(k, (k+1)*4096, (k+1)*4096, (k+1)*4096, (k+1)*4096);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    pdata = '0;
    vdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_vld", {63'b0, vld}, 64'd0);
    chk("reset_data", odata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // One-hot selects V row 2; result visible DIM+1 cycles after start sample
    load_onehot();
    start = 1'b1;
    wait_vld(n);
    chk("onehot_latency", 64'(n - 1), 64'd5);
    chk_row("onehot", 4096, -8192, 12288, -16384);
    drop_start("onehot_vld_fall");

    load_uniform();
    start = 1'b1;
    wait_vld(n);
    chk("uniform_latency", 64'(n - 1), 64'd5);
    chk_row("uniform", 10240, 10240, 10240, 10240);
    drop_start("uniform_vld_fall");

    setp(8192, 8192, 8192, 8192);
    for (int k = 0; k < 4; k++) setv(k, 24576, 24576, 24576, 24576);
    start = 1'b1;
    wait_vld(n);
    chk_row("sat_pos", 32767, 32767, 32767, 32767);
    drop_start("sat_pos_vld_fall");

    for (int k = 0; k < 4; k++) setv(k, -32768, -32768, -32768, -32768);
    start = 1'b1;
    wait_vld(n);
    chk_row("sat_neg", -32768, -32768, -32768, -32768);
    drop_start("sat_neg_vld_fall");

    setp(1, 0, 0, 0);
    setv(0, 4096, 4095, -4096, -4097);
    for (int k = 1; k < 4; k++) setv(k, 1000, -1000, 2000, -2000);
    start = 1'b1;
    wait_vld(n);
    chk_row("round", 1, 0, 0, -1);
    drop_start("round_vld_fall");

    // Abort two cycles after the start sample
    saved = odata;
    load_uniform();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("abort_vld", {63'b0, vld}, 64'd0);
    end
    chk("abort_data", odata, 64'(saved));

    load_onehot();
    start = 1'b1;
    wait_vld(n);
    chk("restart_latency", 64'(n - 1), 64'd5);
    chk_row("restart", 4096, -8192, 12288, -16384);
    drop_start("restart_vld_fall");

    // Inputs disturbed during MAC and DONE must not affect the captured result
    load_uniform();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    setp(-8192, 8192, -8192, 8192);
    for (int k = 0; k < 4; k++) setv(k, -1, 2, -3, 4);
    wait_vld(n);
    chk("hold_latency", 64'(n + 1), 64'd5);
    chk_row("hold_mac", 10240, 10240, 10240, 10240);
    load_onehot();
    repeat (3) @(negedge clk);
    chk("hold_done_vld", {63'b0, vld}, 64'd1);
    chk_row("hold_done", 10240, 10240, 10240, 10240);
    drop_start("hold_vld_fall");

    // Asynchronous reset mid-MAC clears outputs at once
    load_onehot();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", {63'b0, vld}, 64'd0);
    chk("rst_mid_data", odata, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    load_uniform();
    start = 1'b1;
    wait_vld(n);
    chk("post_rst_latency", 64'(n - 1), 64'd5);
    chk_row("post_rst", 10240, 10240, 10240, 10240);
    drop_start("post_rst_vld_fall");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
